// File: rtl/accum_pkg.sv
// Shared types for the accumulator datapath: ALU opcodes, control states and
// the default data width.
package accum_pkg;

  localparam int ACCUM_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_LDA = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_t;

  typedef enum logic {
    WAIT   = 1'b0,
    LOADED = 1'b1
  } state_t;

endpackage

// File: rtl/accum_datapath_if.sv
// Control/data bundle of the accumulator datapath; master drives the strobes
// and operands, slave returns registers, flags and status.
interface accum_datapath_if
  import accum_pkg::*;
#(
  parameter int WIDTH = ACCUM_WIDTH
);

  logic             enA;
  logic             enALU;
  logic             enC;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regC;
  logic             flagZ;
  logic             flagCy;
  logic             flagV;
  logic             res_valid;
  logic             seq_err;

  modport master (
    output enA, enALU, enC, op, din,
    input  regA, regC, flagZ, flagCy, flagV, res_valid, seq_err
  );

  modport slave (
    input  enA, enALU, enC, op, din,
    output regA, regC, flagZ, flagCy, flagV, res_valid, seq_err
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: operates on accumulator C and operand A under the
// registered opcode, returning result, carry/borrow/shift-out and overflow.
module alu_core
  import accum_pkg::*;
#(
  parameter int WIDTH = ACCUM_WIDTH
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cy_o,
  output logic             v_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  // The extra top bit of the difference is the unsigned borrow (C < A).
  assign sum_w  = {1'b0, c_i} + {1'b0, a_i};
  assign diff_w = {1'b0, c_i} - {1'b0, a_i};

  always_comb begin
    res_o = '0;
    cy_o  = 1'b0;
    v_o   = 1'b0;
    case (op_i)
      OP_LDA: res_o = a_i;
      OP_ADD: begin
        res_o = sum_w[MSB:0];
        cy_o  = sum_w[WIDTH];
        v_o   = (c_i[MSB] == a_i[MSB]) && (sum_w[MSB] != c_i[MSB]);
      end
      OP_SUB: begin
        res_o = diff_w[MSB:0];
        cy_o  = diff_w[WIDTH];
        v_o   = (c_i[MSB] != a_i[MSB]) && (diff_w[MSB] != c_i[MSB]);
      end
      OP_AND: res_o = c_i & a_i;
      OP_OR:  res_o = c_i | a_i;
      OP_XOR: res_o = c_i ^ a_i;
      OP_SHL: begin
        res_o = {c_i[MSB-1:0], 1'b0};
        cy_o  = c_i[MSB];
      end
      OP_SHR: begin
        res_o = {1'b0, c_i[MSB:1]};
        cy_o  = c_i[0];
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/accum_datapath.sv
// Accumulator datapath: operand/opcode/accumulator registers, result flags and
// the WAIT/LOADED sequencing FSM around the combinational ALU.
module accum_datapath
  import accum_pkg::*;
#(
  parameter int WIDTH = ACCUM_WIDTH
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic             enA,
  input  logic             enALU,
  input  logic             enC,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] regA,
  output logic [WIDTH-1:0] regC,
  output logic             flagZ,
  output logic             flagCy,
  output logic             flagV,
  output logic             res_valid,
  output logic             seq_err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_a_q;
  logic [WIDTH-1:0] reg_c_q;
  op_t              op_q;
  logic             z_q, cy_q, v_q;
  logic             valid_q;
  logic             err_q;

  logic             commit_w;
  logic             seq_fault_w;
  logic [WIDTH-1:0] alu_res_w;
  logic             alu_cy_w;
  logic             alu_v_w;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op_i  (op_q),
    .a_i   (reg_a_q),
    .c_i   (reg_c_q),
    .res_o (alu_res_w),
    .cy_o  (alu_cy_w),
    .v_o   (alu_v_w)
  );

  // A commit with a simultaneous full reload keeps the FSM in LOADED; the ALU
  // still sees the pre-edge operand and opcode because they are registered.
  always_comb begin
    state_d     = state_q;
    commit_w    = 1'b0;
    seq_fault_w = 1'b0;
    case (state_q)
      WAIT: begin
        seq_fault_w = enC;
        if (enA && enALU) begin
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (enC) begin
          commit_w = 1'b1;
          state_d  = (enA && enALU) ? LOADED : WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= WAIT;
      reg_a_q <= '0;
      reg_c_q <= '0;
      op_q    <= OP_LDA;
      z_q     <= 1'b0;
      cy_q    <= 1'b0;
      v_q     <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enA) begin
        reg_a_q <= din;
      end
      if (enALU) begin
        op_q <= op_t'(op);
      end
      if (commit_w) begin
        reg_c_q <= alu_res_w;
        z_q     <= (alu_res_w == '0);
        cy_q    <= alu_cy_w;
        v_q     <= alu_v_w;
      end
      valid_q <= commit_w;
      err_q   <= err_q | seq_fault_w;
    end
  end

  assign regA      = reg_a_q;
  assign regC      = reg_c_q;
  assign flagZ     = z_q;
  assign flagCy    = cy_q;
  assign flagV     = v_q;
  assign res_valid = valid_q;
  assign seq_err   = err_q;

endmodule

// File: doc/accum_datapath.md
ACCUM_DATAPATH -- requirements
Module: accum_datapath

Interface
REQ-001 The parameter list SHALL be: WIDTH, 8, data path width in bits.
REQ-002 Ports SHALL be:
- CLKb  input  1  system clock, rising-edge active
- RSTb  input  1  asynchronous active-low reset
- enA  input  1  load operand register A from din
- enALU  input  1  latch opcode op into the opcode register
- enC  input  1  commit ALU result into accumulator C
- op  input  3  ALU opcode
- din  input  WIDTH  operand data
- regA  output  WIDTH  operand register
- regC  output  WIDTH  accumulator
- flagZ  output  1  result zero
- flagCy  output  1  carry/borrow/shifted-out bit
- flagV  output  1  signed overflow
- res_valid  output  1  one-cycle commit pulse
- seq_err  output  1  sticky protocol-error flag
REQ-003 The block SHALL have one clock, CLKb, and an asynchronous active-low reset, RSTb.

Function
REQ-004 All state SHALL update on the rising edge of CLKb only.
REQ-005 With enA=1, regA SHALL load din at the edge.
REQ-006 With enALU=1, the opcode register SHALL load op at the edge.
REQ-007 The ALU SHALL be combinational on the registered opcode, regA and regC:
- 000 LDA: A
- 001 ADD: C+A
- 010 SUB: C-A
- 011 AND
- 100 OR
- 101 XOR
- 110 SHL: C<<1
- 111 SHR: C>>1, logical
REQ-008 Carry flag per opcode:
- ADD: flagCy = carry out of bit WIDTH-1.
- SUB: flagCy = 1 when C<A unsigned (borrow).
- SHL: flagCy = C[WIDTH-1].
- SHR: flagCy = C[0].
- All other opcodes: flagCy = 0.
REQ-009 flagV SHALL be two's-complement overflow for ADD/SUB and 0 for all other opcodes.
REQ-010 flagZ SHALL be 1 when the committed result is 0.
REQ-011 The FSM SHALL have two states: WAIT and LOADED.
REQ-012 FSM transitions:
- WAIT→LOADED when enA=1 and enALU=1 in the same cycle.
- enA alone or enALU alone SHALL load its register but leave the state in WAIT.
REQ-013 In LOADED, enC=1 SHALL commit: regC, flagZ, flagCy and flagV update at that edge, and the state returns to WAIT.
REQ-014 res_valid SHALL be 1 for exactly the one cycle following a commit edge.
REQ-015 enC=1 in WAIT SHALL NOT modify regC or the flags, SHALL NOT pulse res_valid, and SHALL set seq_err.
REQ-016 seq_err SHALL stay 1 until reset.
REQ-017 When enC, enA and enALU are all 1 in LOADED:
- The commit SHALL use the pre-edge regA and opcode.
- regA and the opcode SHALL load their new values at the same edge.
- The state SHALL remain LOADED.
REQ-018 In LOADED, enA=1 or enALU=1 without enC SHALL reload the register and stay in LOADED.
REQ-019 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-020 Latency from the enC edge to visible regC SHALL be 0 cycles (registered output at that edge).

Reset
REQ-021 RSTb=0 SHALL immediately, without waiting for a clock edge, force:
- regA, regC and the opcode register to 0
- all flags to 0
- res_valid and seq_err to 0
- the state to WAIT
REQ-022 A reset asserted between load and commit SHALL discard the pending operation; a later enC without a reload SHALL raise seq_err.
REQ-023 After RSTb deasserts, the first rising edge SHALL operate normally.

Structure
REQ-024 A shared package accum_pkg SHALL hold the opcode enum (op_t, 3 bits), the state enum (WAIT, LOADED) and the default WIDTH constant.
REQ-025 The ALU SHALL be a combinational sub-module, alu_core, returning the result, carry and overflow.
REQ-026 accum_datapath SHALL contain all registers and the FSM.

Verification
REQ-027 Reset, then load din=0x05 with op=LDA; next cycle enC → regC=0x05, Z=0, res_valid pulses once.
REQ-028 With C=0xFF: load A=0x01 with op=ADD, then enC → regC=0x00, Z=1, Cy=1, V=0.
REQ-029 With C=0x7F: load A=0x01 with op=ADD, then enC → regC=0x80, V=1. Then load A=0x90 with op=SUB, then enC → regC=0xF0, Cy=1.
REQ-030 enC with no preceding load → regC unchanged, no res_valid, seq_err=1 and stays 1 through further valid commits.
REQ-031 In LOADED (A=0x03, op=ADD, C=0x10): enA=enALU=enC=1 with din=0x20, op=XOR → regC=0x13, state LOADED; the next enC gives regC=0x33.
REQ-032 RSTb pulsed low mid-cycle while in LOADED → all outputs 0 asynchronously; the following enC raises seq_err.
